// File: rtl/i2s_rx_capture_if.sv
// Sample handshake bundle between the I2S capture deserializer (master)
// and the recorder/SRAM-write consumer (slave).
interface i2s_rx_capture_if;
  logic [15:0] o_data;
  logic        o_valid;
  logic        o_channel;
  logic        o_overrun;
  logic        i_ack;

  modport master (output o_data, o_valid, o_channel, o_overrun, input i_ack);
  modport slave  (input o_data, o_valid, o_channel, o_overrun, output i_ack);
endinterface

// File: rtl/i2s_rx_capture.sv
// I2S ADC capture: frames 16-bit MSB-first words on aud_adclrck, hands them
// off with valid/ack. Define I2S_RX_STEREO_EN to capture the right channel too.
module i2s_rx_capture (
  input  logic                     i_BCLK,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic                     i_stop,
  input  logic                     aud_adclrck,
  input  logic                     aud_adcdat,
  output logic                     o_busy,
  i2s_rx_capture_if.master         cap
);

  typedef enum logic [1:0] {IDLE, WAIT_LR, SHIFT} state_t;

  state_t      state;
  logic        lrc_q;
  logic [3:0]  cnt;
  logic [14:0] sreg;
  logic        ch_cur;
  logic        stop_pend;
  logic        lrc_fall;

  assign lrc_fall = lrc_q & ~aud_adclrck;
`ifdef I2S_RX_STEREO_EN
  logic        lrc_rise;
  assign lrc_rise = ~lrc_q & aud_adclrck;
`endif

  always_ff @(posedge i_BCLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      lrc_q         <= 1'b0;
      cnt           <= 4'd0;
      sreg          <= '0;
      ch_cur        <= 1'b0;
      stop_pend     <= 1'b0;
      o_busy        <= 1'b0;
      cap.o_data    <= 16'h0000;
      cap.o_valid   <= 1'b0;
      cap.o_channel <= 1'b0;
      cap.o_overrun <= 1'b0;
    end else begin
      lrc_q <= aud_adclrck;
      // A completing word below overrides this clear: the new word wins.
      if (cap.i_ack) cap.o_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!i_stop && i_start) begin
            state         <= WAIT_LR;
            o_busy        <= 1'b1;
            cap.o_overrun <= 1'b0;
          end
        end
        WAIT_LR: begin
          // The detecting edge is the one-bit delay slot; its data is dropped.
          if (i_stop) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end else if (lrc_fall) begin
            state     <= SHIFT;
            cnt       <= 4'd0;
            ch_cur    <= 1'b0;
            stop_pend <= 1'b0;
          end
`ifdef I2S_RX_STEREO_EN
          else if (lrc_rise) begin
            state     <= SHIFT;
            cnt       <= 4'd0;
            ch_cur    <= 1'b1;
            stop_pend <= 1'b0;
          end
`endif
        end
        SHIFT: begin
          sreg <= {sreg[13:0], aud_adcdat};
          cnt  <= cnt + 4'd1;
          if (i_stop) stop_pend <= 1'b1;
          if (cnt == 4'd15) begin
            cap.o_data    <= {sreg, aud_adcdat};
            cap.o_channel <= ch_cur;
            cap.o_valid   <= 1'b1;
            if (cap.o_valid && !cap.i_ack) cap.o_overrun <= 1'b1;
            if (stop_pend || i_stop) begin
              state  <= IDLE;
              o_busy <= 1'b0;
            end else begin
              state <= WAIT_LR;
            end
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_rx_capture.sv
// Bench for i2s_rx_capture: directed scenarios plus randomized frames, all
// checked every cycle against a frame-level behavioural model.
module tb_i2s_rx_capture;

`ifdef I2S_RX_STEREO_EN
  localparam bit STEREO = 1'b1;
`else
  localparam bit STEREO = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, stop = 1'b0, lrck = 1'b1, dat = 1'b0;
  logic busy;
  i2s_rx_capture_if cap ();

  always #5 clk = ~clk;

  i2s_rx_capture dut (
    .i_BCLK(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop),
    .aud_adclrck(lrck), .aud_adcdat(dat), .o_busy(busy), .cap(cap)
  );

  int checks = 0, failures = 0;
  bit chk_en = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 armed (waiting for a channel boundary), 2 collecting bits
  int          m_phase;
  int          m_left;
  bit          m_stop_seen, m_pch, m_lrc;
  bit          hist[$];
  logic [15:0] m_data;
  bit          m_valid, m_ch, m_ovr, m_busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_left = 0; m_stop_seen = 0; m_pch = 0; m_lrc = 0;
      hist.delete();
      m_data = 16'h0; m_valid = 0; m_ch = 0; m_ovr = 0; m_busy = 0;
    end else begin
      bit fall, rise, done;
      logic [15:0] w;
      fall = m_lrc && !lrck;
      rise = !m_lrc && lrck;
      done = 0;
      w = '0;
      hist.push_back(dat);
      if (hist.size() > 16) void'(hist.pop_front());
      if (m_phase == 0) begin
        if (!stop && start) begin m_phase = 1; m_ovr = 0; end
      end else if (m_phase == 1) begin
        if (stop) m_phase = 0;
        else if (fall) begin m_phase = 2; m_left = 16; m_pch = 0; m_stop_seen = 0; end
        else if (STEREO && rise) begin m_phase = 2; m_left = 16; m_pch = 1; m_stop_seen = 0; end
      end else begin
        m_stop_seen |= stop;
        m_left--;
        if (m_left == 0) begin
          // The last 16 sampled bits, oldest first, are the word MSB..LSB.
          for (int i = 0; i < 16; i++) w[15-i] = hist[i];
          done = 1;
          m_phase = m_stop_seen ? 0 : 1;
        end
      end
      if (done) begin
        if (m_valid && !cap.i_ack) m_ovr = 1;
        m_valid = 1; m_data = w; m_ch = m_pch;
      end else if (cap.i_ack) begin
        m_valid = 0;
      end
      m_lrc = lrck;
      m_busy = (m_phase != 0);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_data",    cap.o_data,    m_data);
      chk("cyc_valid",   cap.o_valid,   m_valid);
      chk("cyc_channel", cap.o_channel, m_ch);
      chk("cyc_overrun", cap.o_overrun, m_ovr);
      chk("cyc_busy",    busy,          m_busy);
    end
  end

  // ---------------- stimulus helpers ----------------
  // ack_at: -1 never, -2 random per cycle, else the slot index to ack in.
  task automatic send_half(input bit l, input logic [15:0] w, input int len,
                           input int ack_at, input int stop_at);
    for (int j = 0; j < len; j++) begin
      @(negedge clk);
      start = 1'b0;
      lrck  = l;
      dat   = (j >= 1 && j <= 16) ? w[16-j] : 1'($urandom);
      cap.i_ack = (ack_at == -2) ? ($urandom_range(0, 3) == 0) : (j == ack_at);
      stop  = (stop_at >= 0 && j >= stop_at);
    end
  endtask

  task automatic idle(input int n, input bit l);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      start = 1'b0; stop = 1'b0; cap.i_ack = 1'b0; lrck = l;
    end
  endtask

  task automatic go_start;
    @(negedge clk);
    lrck = 1'b1; start = 1'b1; stop = 1'b0; cap.i_ack = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] wv;
    cap.i_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", cap.o_data, 16'h0000);
    chk("rst_valid", cap.o_valid, 1'b0);
    chk("rst_channel", cap.o_channel, 1'b0);
    chk("rst_overrun", cap.o_overrun, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    idle(3, 1'b1);

    // First left word; valid must appear exactly on the 17th edge.
    go_start();
    wv = 16'hA5C3;
    send_half(1'b0, wv, 16, -1, -1);
    @(posedge clk); #1;
    chk("a5c3_edge16_valid", cap.o_valid, 1'b0);
    @(negedge clk); dat = wv[0];
    @(posedge clk); #1;
    chk("a5c3_edge17_valid", cap.o_valid, 1'b1);
    chk("a5c3_data", cap.o_data, 16'hA5C3);
    chk("a5c3_channel", cap.o_channel, 1'b0);
    chk("a5c3_overrun", cap.o_overrun, 1'b0);
    idle(4, 1'b0);

    // Unacked consecutive words overrun.
    send_half(1'b1, 16'($urandom), 20, -1, -1);
    send_half(1'b0, 16'h1234, 20, -1, -1);
    send_half(1'b1, 16'($urandom), 20, -1, -1);
    send_half(1'b0, 16'hFFFF, 20, -1, -1);
    chk("ovr_data", cap.o_data, 16'hFFFF);
    chk("ovr_valid", cap.o_valid, 1'b1);
    chk("ovr_flag", cap.o_overrun, 1'b1);
    @(negedge clk); stop = 1'b1;
    idle(2, 1'b0);
    chk("stopped_busy", busy, 1'b0);
    chk("ovr_sticky", cap.o_overrun, 1'b1);
    go_start();
    @(negedge clk); start = 1'b0;
    chk("restart_clears_ovr", cap.o_overrun, 1'b0);
    chk("restart_busy", busy, 1'b1);

    // Completion and ack on the same edge: new word wins, no overrun.
    send_half(1'b0, 16'h5A5A, 20, 16, -1);
    send_half(1'b1, 16'($urandom), 20, 16, -1);
    send_half(1'b0, 16'h3C3C, 20, 16, -1);
    chk("samedge_valid", cap.o_valid, 1'b1);
    chk("samedge_data", cap.o_data, 16'h3C3C);
    chk("samedge_overrun", cap.o_overrun, 1'b0);

    // Stop mid-word: word still completes, then capture halts.
    send_half(1'b1, 16'($urandom), 20, 16, -1);
    send_half(1'b0, 16'h8001, 20, -1, 8);
    chk("stop_data", cap.o_data, 16'h8001);
    chk("stop_busy", busy, 1'b0);
    @(negedge clk); cap.i_ack = 1'b1; stop = 1'b0;
    @(negedge clk); cap.i_ack = 1'b0;
    for (int k = 0; k < 2; k++) begin
      send_half(1'b1, 16'($urandom), 20, -1, -1);
      send_half(1'b0, 16'($urandom), 20, -1, -1);
    end
    chk("stop_nocap_valid", cap.o_valid, 1'b0);
    chk("stop_nocap_data", cap.o_data, 16'h8001);

    // Asynchronous reset mid-word.
    go_start();
    send_half(1'b0, 16'h1111, 10, -1, -1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_data", cap.o_data, 16'h0000);
    chk("arst_valid", cap.o_valid, 1'b0);
    chk("arst_channel", cap.o_channel, 1'b0);
    chk("arst_overrun", cap.o_overrun, 1'b0);
    chk("arst_busy", busy, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      send_half(1'b1, 16'($urandom), 20, -1, -1);
      send_half(1'b0, 16'($urandom), 20, -1, -1);
    end
    chk("postrst_valid", cap.o_valid, 1'b0);
    chk("postrst_busy", busy, 1'b0);

    // Left then right word; right only reported when stereo is built in.
    go_start();
    send_half(1'b0, 16'h0F0F, 20, 18, -1);
    chk("lr_left_data", cap.o_data, 16'h0F0F);
    chk("lr_left_channel", cap.o_channel, 1'b0);
    chk("lr_left_acked", cap.o_valid, 1'b0);
    send_half(1'b1, 16'hF0F0, 20, -1, -1);
    chk("lr_right_data", cap.o_data, STEREO ? 32'hF0F0 : 32'h0F0F);
    chk("lr_right_channel", cap.o_channel, STEREO ? 32'd1 : 32'd0);
    chk("lr_right_valid", cap.o_valid, STEREO ? 32'd1 : 32'd0);
    chk("lr_overrun", cap.o_overrun, 1'b0);

    // Randomized frames, acks, starts and stops.
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clk);
        start = 1'b1; stop = 1'b0; cap.i_ack = 1'b0;
      end
      send_half(k[0], 16'($urandom), int'($urandom_range(17, 24)), -2,
                ($urandom_range(0, 14) == 0) ? int'($urandom_range(0, 19)) : -1);
    end

    idle(2, 1'b0);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
